// File: rtl/pca_write_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pca_write_sequencer: turns I2C write bytes into register-file writes.     |
// | Optional: PCA_ALL_LED_BROADCAST_EN expands ALL_LED writes to every LED.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pca_write_sequencer #(
  parameter logic [7:0] LED_BASE     = 8'h06,
  parameter int         LED_COUNT    = 16,
  parameter logic [7:0] ALL_LED_BASE = 8'hFA
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       byte_ready_o,
  input  logic       mode1_ai_i,
  output logic [7:0] write_register_id_o,
  output logic [7:0] write_register_value_o,
  output logic       write_enable_o,
  output logic       busy_o
);

`ifdef PCA_ALL_LED_BROADCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  localparam int              IDX_W      = $clog2(LED_COUNT + 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(LED_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    BCAST = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       ptr_q, ptr_d;
  logic             pend_start_q, pend_start_d;
  logic             pend_stop_q, pend_stop_d;
  logic             we_q, we_d;
  logic [7:0]       wid_q, wid_d;
  logic [7:0]       wval_q, wval_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       k_q, k_d;
  logic [7:0]       bval_q, bval_d;

  logic       w_xfer;
  logic [7:0] w_all_off;
  logic       w_is_all;
  logic [7:0] w_led_id;
  logic [7:0] w_ptr_next;

  assign byte_ready_o           = (state_q == ADDR) || (state_q == DATA);
  assign w_xfer                 = byte_valid_i && byte_ready_o;
  assign w_all_off              = ptr_q - ALL_LED_BASE;
  assign w_is_all               = (w_all_off[7:2] == 6'd0);
  assign w_led_id               = LED_BASE + 8'({idx_q, 2'b00}) + {6'd0, k_q};
  assign w_ptr_next             = mode1_ai_i ? (ptr_q + 8'd1) : ptr_q;
  assign write_enable_o         = we_q;
  assign write_register_id_o    = wid_q;
  assign write_register_value_o = wval_q;

`ifdef PCA_ALL_LED_BROADCAST_EN
  assign busy_o = (state_q == BCAST);
`else
  assign busy_o = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pend_start_d = pend_start_q;
    pend_stop_d  = pend_stop_q;
    we_d         = 1'b0;
    wid_d        = wid_q;
    wval_d       = wval_q;
    idx_d        = idx_q;
    k_d          = k_q;
    bval_d       = bval_q;

    case (state_q)
      IDLE: begin
        if (start_i) state_d = ADDR;
      end

      ADDR: begin
        if (start_i) begin
          state_d = ADDR;
        end else begin
          if (w_xfer) begin
            ptr_d   = byte_i;
            state_d = DATA;
          end
          if (stop_i) state_d = IDLE;
        end
      end

      DATA: begin
        if (start_i) begin
          state_d = ADDR;
        end else begin
          if (w_xfer) begin
            we_d   = 1'b1;
            wid_d  = ptr_q;
            wval_d = byte_i;
            ptr_d  = w_ptr_next;
          end
          if (BCAST_EN && w_xfer && w_is_all) begin
            // A stop in the accepting cycle is remembered until expansion ends.
            state_d      = BCAST;
            idx_d        = '0;
            k_d          = w_all_off[1:0];
            bval_d       = byte_i;
            pend_start_d = 1'b0;
            pend_stop_d  = stop_i;
          end else if (stop_i) begin
            state_d = IDLE;
          end
        end
      end

      BCAST: begin
        pend_start_d = pend_start_q || start_i;
        pend_stop_d  = pend_stop_q || stop_i;
        if (idx_q != C_IDX_LAST) begin
          we_d   = 1'b1;
          wid_d  = w_led_id;
          wval_d = bval_q;
          idx_d  = idx_q + 1'b1;
        end else begin
          if (pend_start_q || start_i)     state_d = ADDR;
          else if (pend_stop_q || stop_i)  state_d = IDLE;
          else                             state_d = DATA;
          pend_start_d = 1'b0;
          pend_stop_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ptr_q        <= 8'd0;
      pend_start_q <= 1'b0;
      pend_stop_q  <= 1'b0;
      we_q         <= 1'b0;
      wid_q        <= 8'd0;
      wval_q       <= 8'd0;
      idx_q        <= '0;
      k_q          <= 2'd0;
      bval_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      we_q         <= we_d;
      wid_q        <= wid_d;
      wval_q       <= wval_d;
      idx_q        <= idx_d;
      k_q          <= k_d;
      bval_q       <= bval_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pca_write_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pca_write_sequencer: directed self-checking bench for the sequencer.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pca_write_sequencer;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       start_i, stop_i, byte_valid_i, mode1_ai_i;
  logic [7:0] byte_i;
  logic       byte_ready_o, write_enable_o, busy_o;
  logic [7:0] write_register_id_o, write_register_value_o;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_n = 0;
  int busy_cnt = 0;
  int ready_in_busy = 0;
  logic [7:0] log_id[$];
  logic [7:0] log_val[$];
  int         log_cyc[$];

  pca_write_sequencer dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .start_i                (start_i),
    .stop_i                 (stop_i),
    .byte_valid_i           (byte_valid_i),
    .byte_i                 (byte_i),
    .byte_ready_o           (byte_ready_o),
    .mode1_ai_i             (mode1_ai_i),
    .write_register_id_o    (write_register_id_o),
    .write_register_value_o (write_register_value_o),
    .write_enable_o         (write_enable_o),
    .busy_o                 (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Outputs are observed on the falling edge, away from the register update.
  always @(negedge clk) begin
    if (write_enable_o) begin
      log_id.push_back(write_register_id_o);
      log_val.push_back(write_register_value_o);
      log_cyc.push_back(cyc_n);
    end
    if (busy_o) busy_cnt = busy_cnt + 1;
    if (busy_o && byte_ready_o) ready_in_busy = ready_in_busy + 1;
  end

  task automatic cyc(input logic s, input logic p, input logic v, input logic [7:0] b);
    start_i = s; stop_i = p; byte_valid_i = v; byte_i = b;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_log;
    log_id.delete(); log_val.delete(); log_cyc.delete();
    busy_cnt = 0; ready_in_busy = 0;
  endtask

  task automatic check_writes(input string name, input logic [7:0] ids[], input logic [7:0] vals[]);
    tests_run++;
    if (log_id.size() !== ids.size()) begin
      tests_failed++;
      $display("FAIL %s count: got %0d, expected %0d", name, log_id.size(), ids.size());
    end else begin
      for (int i = 0; i < ids.size(); i++) begin
        tests_run++;
        if (log_id[i] !== ids[i] || log_val[i] !== vals[i]) begin
          tests_failed++;
          $display("FAIL %s write %0d: got (%h,%h), expected (%h,%h)",
                   name, i, log_id[i], log_val[i], ids[i], vals[i]);
        end
        if (i > 0) begin
          tests_run++;
          if (log_cyc[i] - log_cyc[i-1] !== 1) begin
            tests_failed++;
            $display("FAIL %s spacing %0d: got %0d cycles, expected 1", name, i,
                     log_cyc[i] - log_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    idle(3);
    tests_run += 5;
    if (write_enable_o !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b, expected 0", write_enable_o); end
    if (write_register_id_o !== 8'h00) begin tests_failed++; $display("FAIL reset_id: got %h, expected 00", write_register_id_o); end
    if (write_register_value_o !== 8'h00) begin tests_failed++; $display("FAIL reset_val: got %h, expected 00", write_register_value_o); end
    if (byte_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b, expected 0", byte_ready_o); end
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
    rst_ni = 1'b1;
    idle(2);
  endtask

  task automatic test_auto_inc;
    clear_log();
    mode1_ai_i = 1'b1;
    cyc(1, 0, 0, 8'h00);
    tests_run++;
    if (byte_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ai_ready_addr: got %b, expected 1", byte_ready_o); end
    cyc(0, 0, 1, 8'h06);
    cyc(0, 0, 1, 8'h11);
    cyc(0, 0, 1, 8'h22);
    cyc(0, 0, 1, 8'h33);
    cyc(0, 0, 1, 8'h44);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    check_writes("auto_inc", '{8'h06, 8'h07, 8'h08, 8'h09}, '{8'h11, 8'h22, 8'h33, 8'h44});
    tests_run++;
    if (byte_ready_o !== 1'b0) begin tests_failed++; $display("FAIL ai_idle_ready: got %b, expected 0", byte_ready_o); end
  endtask

  task automatic test_wrap;
    clear_log();
    mode1_ai_i = 1'b1;
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'hFF);
    cyc(0, 0, 1, 8'hAA);
    cyc(0, 0, 1, 8'hBB);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    check_writes("wrap", '{8'hFF, 8'h00}, '{8'hAA, 8'hBB});
  endtask

  task automatic test_no_ai;
    clear_log();
    mode1_ai_i = 1'b0;
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h08);
    cyc(0, 0, 1, 8'h01);
    cyc(0, 0, 1, 8'h02);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    check_writes("no_ai", '{8'h08, 8'h08}, '{8'h01, 8'h02});
    mode1_ai_i = 1'b1;
  endtask

  task automatic test_reserved;
    clear_log();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h50);
    cyc(0, 0, 1, 8'h99);
    cyc(0, 0, 1, 8'h3C);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    check_writes("reserved", '{8'h50, 8'h51}, '{8'h99, 8'h3C});
  endtask

  task automatic test_start_priority;
    clear_log();
    // Byte offered in IDLE must be ignored.
    cyc(0, 0, 1, 8'h77);
    tests_run++;
    if (byte_ready_o !== 1'b0) begin tests_failed++; $display("FAIL idle_ready: got %b, expected 0", byte_ready_o); end
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h10);
    cyc(1, 1, 1, 8'h55);
    tests_run++;
    if (byte_ready_o !== 1'b1) begin tests_failed++; $display("FAIL prio_ready: got %b, expected 1", byte_ready_o); end
    cyc(0, 0, 1, 8'h30);
    cyc(0, 0, 1, 8'h31);
    cyc(0, 1, 0, 8'h00);
    idle(2);
    check_writes("start_prio", '{8'h30}, '{8'h31});
  endtask

  task automatic test_broadcast;
    clear_log();
    mode1_ai_i = 1'b1;
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'hFC);
    cyc(0, 0, 1, 8'h5A);
    idle(3);
    cyc(0, 1, 0, 8'h00);
`ifdef PCA_ALL_LED_BROADCAST_EN
    cyc(0, 0, 1, 8'hEE);
`endif
    idle(20);
`ifdef PCA_ALL_LED_BROADCAST_EN
    begin
      logic [7:0] ids[] = new[17];
      logic [7:0] vals[] = new[17];
      ids[0] = 8'hFC; vals[0] = 8'h5A;
      for (int i = 0; i < 16; i++) begin
        ids[i+1] = 8'(8'h08 + 4 * i);
        vals[i+1] = 8'h5A;
      end
      check_writes("bcast", ids, vals);
    end
    tests_run += 2;
    if (busy_cnt !== 17) begin tests_failed++; $display("FAIL bcast_busy: got %0d cycles, expected 17", busy_cnt); end
    if (ready_in_busy !== 0) begin tests_failed++; $display("FAIL bcast_ready: got %0d ready cycles, expected 0", ready_in_busy); end
`else
    check_writes("bcast_off", '{8'hFC}, '{8'h5A});
    tests_run++;
    if (busy_cnt !== 0) begin tests_failed++; $display("FAIL bcast_off_busy: got %0d cycles, expected 0", busy_cnt); end
`endif
    tests_run++;
    if (byte_ready_o !== 1'b0) begin tests_failed++; $display("FAIL bcast_end_idle: got ready %b, expected 0", byte_ready_o); end
  endtask

  task automatic test_reset_abort;
    int target;
    int seen;
    bit hit;
    clear_log();
    hit = 1'b0;
    seen = 0;
    cyc(1, 0, 0, 8'h00);
`ifdef PCA_ALL_LED_BROADCAST_EN
    target = 5;
    cyc(0, 0, 1, 8'hFA);
    cyc(0, 0, 1, 8'h33);
`else
    target = 1;
    cyc(0, 0, 1, 8'h10);
    cyc(0, 0, 1, 8'h33);
`endif
    for (int i = 0; i < 40; i++) begin
      if (log_id.size() >= target) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL abort_wait: got %0d writes, expected %0d", log_id.size(), target);
    end
`ifdef PCA_ALL_LED_BROADCAST_EN
    tests_run++;
    if (log_id.size() > 0 && log_id[log_id.size()-1] !== 8'h12) begin
      tests_failed++;
      $display("FAIL abort_fifth_id: got %h, expected 12", log_id[log_id.size()-1]);
    end
`endif
    rst_ni = 1'b0;
    #1;
    tests_run += 4;
    if (write_enable_o !== 1'b0) begin tests_failed++; $display("FAIL abort_we: got %b, expected 0", write_enable_o); end
    if (write_register_id_o !== 8'h00 || write_register_value_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_data: got (%h,%h), expected (00,00)", write_register_id_o, write_register_value_o);
    end
    if (byte_ready_o !== 1'b0) begin tests_failed++; $display("FAIL abort_ready: got %b, expected 0", byte_ready_o); end
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b, expected 0", busy_o); end
    seen = log_id.size();
    idle(2);
    rst_ni = 1'b1;
    idle(25);
    tests_run += 2;
    if (log_id.size() !== seen) begin tests_failed++; $display("FAIL abort_no_writes: got %0d writes, expected %0d", log_id.size(), seen); end
    if (byte_ready_o !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: got ready %b, expected 0", byte_ready_o); end
  endtask

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
    mode1_ai_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_auto_inc();
    test_wrap();
    test_no_ai();
    test_reserved();
    test_start_priority();
    test_broadcast();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pca_write_sequencer.md
PCA_WRITE_SEQUENCER -- requirements
Module: pca_write_sequencer

Interface
REQ-001 Parameter LED_BASE, default 8'h06, register ID of LED_0_ON_L.
REQ-002 Parameter LED_COUNT, default 16, number of LED channels, each 4 registers wide.
REQ-003 Parameter ALL_LED_BASE, default 8'hFA, register ID of ALL_LED_ON_L.
REQ-004 Port clk_i, input, 1, single clock; all logic on rising edge.
REQ-005 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 Port start_i, input, 1, one-cycle pulse marking the I2C (re)start of a write transaction addressed to this device.
REQ-007 Port stop_i, input, 1, one-cycle pulse marking the I2C stop.
REQ-008 Port byte_valid_i, input, 1, received byte available.
REQ-009 Port byte_i, input, 8, received byte.
REQ-010 Port byte_ready_o, output, 1, sequencer can accept a byte; transfer occurs when byte_valid_i and byte_ready_o are both high.
REQ-011 Port mode1_ai_i, input, 1, MODE1 auto-increment bit from the register file.
REQ-012 Port write_register_id_o, output, 8, register file write address.
REQ-013 Port write_register_value_o, output, 8, register file write data.
REQ-014 Port write_enable_o, output, 1, register file write strobe.
REQ-015 Port busy_o, output, 1, high while a broadcast expansion is in progress.

Function
REQ-016 States: IDLE, ADDR (awaiting pointer byte), DATA (awaiting data bytes), BCAST (emitting broadcast writes).
REQ-017 byte_ready_o is high only in ADDR and DATA; bytes presented in IDLE or BCAST are not consumed.
REQ-018 start_i moves IDLE/ADDR/DATA to ADDR the next cycle; stop_i moves ADDR/DATA to IDLE the next cycle; start_i takes priority over stop_i and over a byte transfer in the same cycle.
REQ-019 Byte accepted in ADDR loads the 8-bit pointer, generates no write, and moves to DATA.
REQ-020 Byte accepted in DATA at cycle N to a non-broadcast pointer: in cycle N+1, write_enable_o=1, id=pointer, value=byte; write_enable_o is otherwise 0 unless another transfer or broadcast drives it.
REQ-021 Auto-increment: after each data byte (including a broadcast), pointer <= pointer+1 modulo 256 if mode1_ai_i was 1 at acceptance; otherwise pointer is unchanged. 8'hFF wraps to 8'h00.
REQ-022 Back-to-back accepted data bytes produce back-to-back write cycles with no bubble; the sequencer inserts no idle cycle itself.
REQ-023 Writes to reserved IDs (0x46..0xF9) are passed through unchanged; the register file owns their handling.
REQ-024 In BCAST, start_i or stop_i is recorded, not acted on; at broadcast completion the state becomes ADDR if start_i was recorded, else IDLE if stop_i was recorded, else DATA.
REQ-025 busy_o equals (state == BCAST).

Reset
REQ-026 On rst_ni low, asynchronously: state IDLE; pointer 0; pending start/stop cleared; write_enable_o, write_register_id_o, write_register_value_o, byte_ready_o, and busy_o all 0.
REQ-027 Reset asserted mid-broadcast aborts it immediately; no further writes are issued after deassertion.

Configuration
REQ-028 Macro PCA_ALL_LED_BROADCAST_EN.
REQ-029 Defined: a data byte accepted with pointer = ALL_LED_BASE+k (k=0..3) at cycle N enters BCAST.
  - Cycle N+1: write to ALL_LED_BASE+k.
  - Cycles N+2..N+1+LED_COUNT: writes to LED_BASE+4*i+k, i=0..LED_COUNT-1 ascending, all with the same value.
  - The state then leaves BCAST per REQ-024.
  - byte_ready_o stays low from N+1 through the last broadcast write.
REQ-030 Undefined: ALL_LED IDs are ordinary single writes per REQ-020, BCAST is unreachable, and busy_o is tied 0.

Verification
REQ-031 start, byte 0x06, AI=1, bytes 0x11 0x22 0x33 0x44, stop -> writes (0x06,0x11)(0x07,0x22)(0x08,0x33)(0x09,0x44) on 4 consecutive cycles, then IDLE.
REQ-032 start, byte 0xFF, AI=1, bytes 0xAA 0xBB -> writes (0xFF,0xAA)(0x00,0xBB); wrap verified.
REQ-033 AI=0, pointer 0x08, bytes 0x01 0x02 -> writes (0x08,0x01)(0x08,0x02).
REQ-034 With PCA_ALL_LED_BROADCAST_EN, pointer 0xFC, byte 0x5A:
  - writes (0xFC,0x5A), then (0x08,0x5A)(0x0C,0x5A)...(0x44,0x5A), 17 cycles.
  - busy_o high for 17 cycles.
  - stop_i pulsed mid-broadcast -> IDLE after the last write.
  - without the macro -> the single write (0xFC,0x5A) only.
REQ-035 start_i and byte_valid_i asserted together in DATA -> no write, state ADDR; rst_ni low at broadcast write 5 -> all outputs 0 and no writes after release.
